// File: rtl/add_pkg.sv
// Shared definitions for the chunked sequential adder: FSM encoding, default
// geometry and signed saturation constants.
package add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int ADD_W     = 32;
  localparam int ADD_CHUNK = 8;
  localparam int NCH       = ADD_W / ADD_CHUNK;
  localparam int CNT_W     = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [ADD_W-1:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [ADD_W-1:0] SAT_NEG = 32'h8000_0000;

  // A single-chunk build still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_chunk.sv
// CHUNK-bit combinational ripple adder slice with carry in and carry out.
module add_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] sum;

  assign sum  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign s    = sum[CHUNK-1:0];
  assign cout = sum[CHUNK];

endmodule

// File: rtl/add_32bits_seq.sv
// Multi-cycle W-bit adder, CHUNK bits per cycle LSB first, carry rippled through
// a register. Optional signed saturation of Y on overflow under ADD32_SAT_EN.
module add_32bits_seq
  import add_pkg::*;
#(
  parameter int W     = ADD_W,
  parameter int CHUNK = ADD_CHUNK
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Y,
  output logic         C_OUT,
  output logic         OVF
);

  localparam int NCH_L   = W / CHUNK;
  localparam int CNT_W_L = cnt_width(NCH_L);
  localparam logic [CNT_W_L-1:0] LAST = CNT_W_L'(NCH_L - 1);

  state_t               state, state_nx;
  logic [CNT_W_L-1:0]   cnt;
  logic                 carry;
  logic [W-1:0]         a_sh, b_sh;
  logic                 sign_a, sign_b;
  logic [CHUNK-1:0]     s;
  logic                 cout;
  logic [W-1:0]         y_wr;
  logic [W-1:0]         y_final;
  logic                 ovf_nx;
  logic                 accept;
  logic                 last;
  logic [1:0]           rst_sync;
  logic                 rst_int_n;

`ifdef ADD32_SAT_EN
  function automatic logic [W-1:0] sat_y(input logic [W-1:0] y, input logic ovf,
                                         input logic neg);
    if (!ovf)
      return y;
    return neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  endfunction
`endif

  // Reset asserts immediately, deasserts two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rst_sync <= 2'b00;
    else
      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  add_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_sh[CHUNK-1:0]),
    .b    (b_sh[CHUNK-1:0]),
    .cin  (carry),
    .s    (s),
    .cout (cout)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && (state == ST_IDLE);
  assign last      = (state == ST_RUN) && (cnt == LAST);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (in_valid)     state_nx = ST_RUN;
      ST_RUN:  if (cnt == LAST)  state_nx = ST_DONE;
      ST_DONE: if (out_ready)    state_nx = ST_IDLE;
      default:                   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    y_wr = Y;
    for (int i = 0; i < NCH_L; i++) begin
      if (cnt == CNT_W_L'(i))
        y_wr[i*CHUNK +: CHUNK] = s;
    end
  end

  // The top chunk's sum bit is the result sign on the final RUN cycle.
  assign ovf_nx = (sign_a == sign_b) && (s[CHUNK-1] != sign_a);

`ifdef ADD32_SAT_EN
  assign y_final = sat_y(y_wr, ovf_nx, sign_a);
`else
  assign y_final = y_wr;
`endif

  // Stage: control, carry chain and result registers
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      Y     <= '0;
      C_OUT <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt   <= '0;
        carry <= 1'b0;
      end else if (state == ST_RUN) begin
        cnt   <= cnt + CNT_W_L'(1);
        carry <= cout;
        Y     <= last ? y_final : y_wr;
        if (last) begin
          C_OUT <= cout;
          OVF   <= ovf_nx;
        end
      end
    end
  end

  // Stage: operand shift registers, loaded only on the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh   <= A;
      b_sh   <= B;
      sign_a <= A[W-1];
      sign_b <= B[W-1];
    end else if (state == ST_RUN) begin
      a_sh <= a_sh >> CHUNK;
      b_sh <= b_sh >> CHUNK;
    end
  end

endmodule

// File: tb/tb_add_32bits_seq.sv
// Scoreboard bench for add_32bits_seq: directed vectors, backpressure,
// mid-operation reset and back-to-back random operations.
module tb_add_32bits_seq;
  import add_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] Y;
  logic        C_OUT;
  logic        OVF;

  add_32bits_seq #(.W(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .C_OUT     (C_OUT),
    .OVF       (OVF)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] y;
    logic        c;
    logic        o;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare on the cycle the result is handed over.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got Y=%h with empty scoreboard", Y);
      end else begin
        mon_e = sb.pop_front();
        check("result_y", Y, mon_e.y);
        check("result_c_out", {31'b0, C_OUT}, {31'b0, mon_e.c});
        check("result_ovf", {31'b0, OVF}, {31'b0, mon_e.o});
      end
    end
  end

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] s;
    s   = {1'b0, a} + {1'b0, b};
    e.y = s[31:0];
    e.c = s[32];
    e.o = (a[31] == b[31]) && (s[31] != a[31]);
`ifdef ADD32_SAT_EN
    if (e.o) e.y = a[31] ? SAT_NEG : SAT_POS;
`endif
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] y, input logic c, input logic o);
    exp_t e;
    e.y = y; e.c = c; e.o = o;
    return e;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("in_ready_wait", {31'b0, in_ready}, 32'd1);
    A = a; B = b; in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!out_valid && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("out_valid_latency", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain", sb.size(), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_y"}, Y, 32'd0);
    check({tag, "_c_out"}, {31'b0, C_OUT}, 32'd0);
    check({tag, "_ovf"}, {31'b0, OVF}, 32'd0);
  endtask

  task automatic directed(input logic [31:0] a, input logic [31:0] b, input exp_t e);
    issue(a, b, e);
    wait_valid(NCH + 1);
    drain();
  endtask

  logic [31:0] held_y;
  logic [31:0] ra, rb;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_reset_vals("idle_hold");

    directed(32'h0000_0005, 32'h0000_0003, mk(32'h0000_0008, 1'b0, 1'b0));
    directed(32'h0000_00FF, 32'h0000_0001, mk(32'h0000_0100, 1'b0, 1'b0));
    directed(32'h00FF_00FF, 32'h0001_0001, mk(32'h0100_0100, 1'b0, 1'b0));
    directed(32'h1234_5678, 32'h1111_1111, mk(32'h2345_6789, 1'b0, 1'b0));
    directed(32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0000_0000, 1'b1, 1'b0));
    directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'hFFFF_FFFE, 1'b1, 1'b0));
`ifdef ADD32_SAT_EN
    directed(32'h7FFF_FFFF, 32'h0000_0001, mk(32'h7FFF_FFFF, 1'b0, 1'b1));
    directed(32'h8000_0000, 32'h8000_0000, mk(32'h8000_0000, 1'b1, 1'b1));
`else
    directed(32'h7FFF_FFFF, 32'h0000_0001, mk(32'h8000_0000, 1'b0, 1'b1));
    directed(32'h8000_0000, 32'h8000_0000, mk(32'h0000_0000, 1'b1, 1'b1));
`endif

    // Backpressure: result must hold and new operands must be ignored.
    out_ready = 1'b0;
    issue(32'h0F0F_0F0F, 32'h0101_0101, mk(32'h1010_1010, 1'b0, 1'b0));
    wait_valid(NCH + 1);
    held_y = Y;
    check("bp_held_value", held_y, 32'h1010_1010);
    for (int i = 0; i < 10; i++) begin
      A = $urandom; B = $urandom; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_y_stable", Y, held_y);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    check("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    check("bp_scoreboard_empty", sb.size(), 32'd0);

    // Reset during the third RUN chunk.
    issue(32'hAAAA_AAAA, 32'h5555_5555, mk(32'hFFFF_FFFF, 1'b0, 1'b0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_vals("midop_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    directed(32'h0000_1234, 32'h0000_4321, mk(32'h0000_5555, 1'b0, 1'b0));

    // Back-to-back random operations against the reference model.
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 3) begin ra = 32'h7FFF_0000; rb = 32'h7FFF_0000; end
      if (i == 7) begin ra = 32'h8000_0001; rb = 32'hFFFF_FFFF; end
      issue(ra, rb, model(ra, rb));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
